// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator. Divides clk into a pixel tick,
// runs horizontal/vertical counters and decodes sync, blanking and
// end-of-frame strobes from them.
// Optional feature macro: VGA_SYNC_OUTREG_EN -- when defined, hsync/vsync
// are registered on pixel ticks (glitch-free, one pixel period of lag);
// when undefined they are decoded combinationally from the counters.
// PIX_DIV must lie in 1..16; H_TOTAL and V_TOTAL must not exceed 1024.
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned PIX_DIV   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       p_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame_start
);

  localparam int unsigned DIV_W   = 4;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [CNT_W-1:0] h_cnt, h_nxt;
  logic [CNT_W-1:0] v_cnt, v_nxt;
  logic             h_wrap;
  logic             v_wrap;
  logic             hsync_raw;
  logic             vsync_raw;

  // Pixel strobe and wrap decodes from the current counter state
  assign p_tick = (div_cnt == DIV_LAST);
  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // Next-state for divider and raster counters; counters only move on p_tick
  always_comb begin
    div_nxt = div_cnt;
    h_nxt   = h_cnt;
    v_nxt   = v_cnt;
    if (p_tick) begin
      div_nxt = '0;
      if (h_wrap) begin
        h_nxt = '0;
        v_nxt = v_wrap ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_nxt = h_cnt + CNT_W'(1);
      end
    end else begin
      div_nxt = div_cnt + DIV_W'(1);
    end
  end

  // Counter state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= div_nxt;
      h_cnt   <= h_nxt;
      v_cnt   <= v_nxt;
    end
  end

  // Coordinate, blanking and end-of-frame decodes (zero latency)
  assign pix_x       = h_cnt;
  assign pix_y       = v_cnt;
  assign video_on    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign frame_start = p_tick && h_wrap && v_wrap;

  // Active-low sync windows
  assign hsync_raw = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
  assign vsync_raw = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));

`ifdef VGA_SYNC_OUTREG_EN
  logic hsync_q;
  logic vsync_q;

  // Sync outputs retimed on pixel ticks; lag the coordinates by one pixel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else if (p_tick) begin
      hsync_q <= hsync_raw;
      vsync_q <= vsync_raw;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
`else
  assign hsync = hsync_raw;
  assign vsync = vsync_raw;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen: three instances (default timing, tiny timing
// with PIX_DIV=1, tiny timing with PIX_DIV=3) checked every clk against a
// reference model through per-instance expected-value queues.
module tb_vga_sync_gen;

`ifdef VGA_SYNC_OUTREG_EN
  localparam bit OUTREG = 1'b1;
`else
  localparam bit OUTREG = 1'b0;
`endif

  typedef struct packed {
    logic       pt;
    logic       hs;
    logic       vs;
    logic       von;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  logic clk;
  logic reset_n;

  logic       p_tick_a, hsync_a, vsync_a, video_on_a, frame_start_a;
  logic [9:0] pix_x_a, pix_y_a;
  logic       p_tick_b, hsync_b, vsync_b, video_on_b, frame_start_b;
  logic [9:0] pix_x_b, pix_y_b;
  logic       p_tick_c, hsync_c, vsync_c, video_on_c, frame_start_c;
  logic [9:0] pix_x_c, pix_y_c;

  int checks   = 0;
  int failures = 0;
  int k        = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  // Statistics gathered from observed DUT outputs while streaming
  int a_hs_low, a_vid_low, a_first_hs_x, a_y_step_x;
  int b_hs_low, b_vs_low, b_vid_on, b_first_hs_x;
  int b_fs_k[$];
  int c_fs_k[$];

  vga_sync_gen u_a (
    .clk(clk), .reset_n(reset_n), .p_tick(p_tick_a), .hsync(hsync_a),
    .vsync(vsync_a), .video_on(video_on_a), .pix_x(pix_x_a), .pix_y(pix_y_a),
    .frame_start(frame_start_a)
  );

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .PIX_DIV(1)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .p_tick(p_tick_b), .hsync(hsync_b),
    .vsync(vsync_b), .video_on(video_on_b), .pix_x(pix_x_b), .pix_y(pix_y_b),
    .frame_start(frame_start_b)
  );

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .PIX_DIV(3)
  ) u_c (
    .clk(clk), .reset_n(reset_n), .p_tick(p_tick_c), .hsync(hsync_c),
    .vsync(vsync_c), .video_on(video_on_c), .pix_x(pix_x_c), .pix_y(pix_y_c),
    .frame_start(frame_start_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clk edges seen since reset release
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) k <= 0;
    else          k <= k + 1;
  end

  // Reference raster after k post-reset edges
  function automatic exp_t model(input int kk, input int hd, input int hf, input int hs,
                                 input int hb, input int vd, input int vf, input int vs,
                                 input int vb, input int d);
    exp_t e;
    int ht, vt, n, x, y, xs, ys;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    n  = kk / d;
    x  = n % ht;
    y  = (n / ht) % vt;
    e.pt  = ((kk % d) == d - 1);
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.von = (x < hd) && (y < vd);
    e.fs  = e.pt && (x == ht - 1) && (y == vt - 1);
    if (OUTREG) begin
      if (n == 0) begin
        e.hs = 1'b1;
        e.vs = 1'b1;
      end else begin
        xs   = (n - 1) % ht;
        ys   = ((n - 1) / ht) % vt;
        e.hs = !(xs >= hd + hf && xs < hd + hf + hs);
        e.vs = !(ys >= vd + vf && ys < vd + vf + vs);
      end
    end else begin
      e.hs = !(x >= hd + hf && x < hd + hf + hs);
      e.vs = !(y >= vd + vf && y < vd + vf + vs);
    end
    return e;
  endfunction

  task automatic clear_stats();
    a_hs_low = 0; a_vid_low = 0; a_first_hs_x = -1; a_y_step_x = -1;
    b_hs_low = 0; b_vs_low = 0; b_vid_on = 0; b_first_hs_x = -1;
    b_fs_k.delete();
    c_fs_k.delete();
  endtask

  // Run n clks: predict at each edge, compare all outputs at the following negedge
  task automatic test_stream(input int n);
    exp_t ea, eb, ec, oa, ob, oc;
    logic [9:0] prev_y_a;
    for (int i = 0; i < n; i++) begin
      prev_y_a = pix_y_a;
      @(posedge clk);
      #1;
      q_a.push_back(model(k, 640, 16, 96, 48, 480, 10, 2, 33, 2));
      q_b.push_back(model(k, 8, 2, 2, 2, 4, 1, 1, 1, 1));
      q_c.push_back(model(k, 8, 2, 2, 2, 4, 1, 1, 1, 3));
      @(negedge clk);
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      ec = q_c.pop_front();
      oa = exp_t'({p_tick_a, hsync_a, vsync_a, video_on_a, frame_start_a, pix_x_a, pix_y_a});
      ob = exp_t'({p_tick_b, hsync_b, vsync_b, video_on_b, frame_start_b, pix_x_b, pix_y_b});
      oc = exp_t'({p_tick_c, hsync_c, vsync_c, video_on_c, frame_start_c, pix_x_c, pix_y_c});
      checks++;
      if (oa !== ea) begin
        failures++;
        if (failures <= 20)
          $display("FAIL stream_a k=%0d got pt/hs/vs/von/fs=%b%b%b%b%b x=%0d y=%0d expected %b%b%b%b%b x=%0d y=%0d",
                   k, oa.pt, oa.hs, oa.vs, oa.von, oa.fs, oa.x, oa.y,
                   ea.pt, ea.hs, ea.vs, ea.von, ea.fs, ea.x, ea.y);
      end
      checks++;
      if (ob !== eb) begin
        failures++;
        if (failures <= 20)
          $display("FAIL stream_b k=%0d got pt/hs/vs/von/fs=%b%b%b%b%b x=%0d y=%0d expected %b%b%b%b%b x=%0d y=%0d",
                   k, ob.pt, ob.hs, ob.vs, ob.von, ob.fs, ob.x, ob.y,
                   eb.pt, eb.hs, eb.vs, eb.von, eb.fs, eb.x, eb.y);
      end
      checks++;
      if (oc !== ec) begin
        failures++;
        if (failures <= 20)
          $display("FAIL stream_c k=%0d got pt/hs/vs/von/fs=%b%b%b%b%b x=%0d y=%0d expected %b%b%b%b%b x=%0d y=%0d",
                   k, oc.pt, oc.hs, oc.vs, oc.von, oc.fs, oc.x, oc.y,
                   ec.pt, ec.hs, ec.vs, ec.von, ec.fs, ec.x, ec.y);
      end
      if (oa.pt) begin
        if (!oa.hs) begin
          a_hs_low++;
          if (a_first_hs_x < 0) a_first_hs_x = int'(oa.x);
        end
        if (!oa.von) a_vid_low++;
      end
      if (oa.y != prev_y_a && a_y_step_x < 0) a_y_step_x = int'(oa.x);
      if (ob.pt) begin
        if (!ob.hs) begin
          b_hs_low++;
          if (b_first_hs_x < 0) b_first_hs_x = int'(ob.x);
        end
        if (!ob.vs) b_vs_low++;
        if (ob.von) b_vid_on++;
      end
      if (ob.fs) b_fs_k.push_back(k);
      if (oc.fs) c_fs_k.push_back(k);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    test_stream(3);
    checks++;
    if (pix_x_a !== 10'd0 || pix_y_a !== 10'd0 || hsync_a !== 1'b1 || vsync_a !== 1'b1 ||
        video_on_a !== 1'b1 || frame_start_a !== 1'b0 || p_tick_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_a got x=%0d y=%0d hs=%b vs=%b von=%b fs=%b pt=%b expected 0 0 1 1 1 0 0",
               pix_x_a, pix_y_a, hsync_a, vsync_a, video_on_a, frame_start_a, p_tick_a);
    end
    checks++;
    if (p_tick_b !== 1'b1) begin
      failures++;
      $display("FAIL reset_b_ptick got %b expected 1", p_tick_b);
    end
  endtask

  task automatic test_release();
    reset_n = 1'b1;
    test_stream(1);
    checks++;
    if (p_tick_a !== 1'b1 || pix_x_a !== 10'd0) begin
      failures++;
      $display("FAIL release_edge1 got pt=%b x=%0d expected pt=1 x=0", p_tick_a, pix_x_a);
    end
    test_stream(1);
    checks++;
    if (p_tick_a !== 1'b0 || pix_x_a !== 10'd1) begin
      failures++;
      $display("FAIL release_edge2 got pt=%b x=%0d expected pt=0 x=1", p_tick_a, pix_x_a);
    end
  endtask

  task automatic test_line();
    clear_stats();
    test_stream(1600);
    checks++;
    if (a_hs_low != 96) begin
      failures++;
      $display("FAIL line_hsync_ticks got %0d expected 96", a_hs_low);
    end
    checks++;
    if (a_first_hs_x != (OUTREG ? 657 : 656)) begin
      failures++;
      $display("FAIL line_hsync_start got %0d expected %0d", a_first_hs_x, OUTREG ? 657 : 656);
    end
    checks++;
    if (a_vid_low != 160) begin
      failures++;
      $display("FAIL line_blank_ticks got %0d expected 160", a_vid_low);
    end
    checks++;
    if (a_y_step_x != 0 || pix_y_a !== 10'd1 || pix_x_a !== 10'd1) begin
      failures++;
      $display("FAIL line_wrap got step_x=%0d x=%0d y=%0d expected 0 1 1", a_y_step_x, pix_x_a, pix_y_a);
    end
  endtask

  task automatic test_small_frame();
    reset_n = 1'b0;
    test_stream(2);
    reset_n = 1'b1;
    clear_stats();
    test_stream(294);
    checks++;
    if (b_fs_k.size() != 3) begin
      failures++;
      $display("FAIL frame_start_count got %0d expected 3", b_fs_k.size());
    end else begin
      checks++;
      if (b_fs_k[0] != 97 || b_fs_k[1] - b_fs_k[0] != 98 || b_fs_k[2] - b_fs_k[1] != 98) begin
        failures++;
        $display("FAIL frame_period got %0d %0d %0d expected 97 195 293", b_fs_k[0], b_fs_k[1], b_fs_k[2]);
      end
    end
    checks++;
    if (b_vs_low != 42) begin
      failures++;
      $display("FAIL frame_vsync_ticks got %0d expected 42", b_vs_low);
    end
    checks++;
    if (b_vid_on != 96) begin
      failures++;
      $display("FAIL frame_video_ticks got %0d expected 96", b_vid_on);
    end
    checks++;
    if (b_hs_low != 42 || b_first_hs_x != (OUTREG ? 11 : 10)) begin
      failures++;
      $display("FAIL small_hsync got ticks=%0d start=%0d expected 42 %0d", b_hs_low, b_first_hs_x, OUTREG ? 11 : 10);
    end
    checks++;
    if (c_fs_k.size() != 1 || (c_fs_k.size() == 1 && c_fs_k[0] != 293)) begin
      failures++;
      $display("FAIL div3_frame_start got count=%0d expected one at k=293", c_fs_k.size());
    end
  endtask

  task automatic test_reset_mid();
    reset_n = 1'b0;
    test_stream(1);
    reset_n = 1'b1;
    test_stream(600);
    checks++;
    if (pix_x_a !== 10'd300) begin
      failures++;
      $display("FAIL mid_precondition got x=%0d expected 300", pix_x_a);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (pix_x_a !== 10'd0 || pix_y_a !== 10'd0 || hsync_a !== 1'b1 || vsync_a !== 1'b1 ||
        pix_x_c !== 10'd0 || pix_y_c !== 10'd0 || hsync_c !== 1'b1 || vsync_c !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_async got a=(%0d,%0d,%b,%b) c=(%0d,%0d,%b,%b) expected (0,0,1,1)",
               pix_x_a, pix_y_a, hsync_a, vsync_a, pix_x_c, pix_y_c, hsync_c, vsync_c);
    end
    test_stream(3);
    reset_n = 1'b1;
    clear_stats();
    test_stream(300);
    checks++;
    if (b_fs_k.size() < 2 || b_fs_k[0] != 97 || b_fs_k[1] != 195) begin
      failures++;
      $display("FAIL mid_next_frame got count=%0d first=%0d expected first at k=97 then 195",
               b_fs_k.size(), (b_fs_k.size() > 0) ? b_fs_k[0] : -1);
    end
    checks++;
    if (c_fs_k.size() != 1 || (c_fs_k.size() == 1 && c_fs_k[0] != 293)) begin
      failures++;
      $display("FAIL mid_next_frame_div3 got count=%0d expected one at k=293", c_fs_k.size());
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_line();
    test_small_frame();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
